// File: rtl/usb_bus_pkg.sv
// Shared encodings and 48 MHz default timing for the USB bus-state logic.
package usb_bus_pkg;

    // Decoded line value, numbered as seen on the line_state output.
    typedef enum logic [1:0] {
        LS_SE0 = 2'd0,
        LS_J   = 2'd1,
        LS_K   = 2'd2,
        LS_SE1 = 2'd3
    } line_state_t;

    // Device bus state, numbered as seen on the bus_state output.
    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_BUS_RESET = 2'd1,
        ST_SUSPEND   = 2'd2,
        ST_RESUME    = 2'd3
    } bus_state_t;

    // Timing for a 48 MHz clock: ~21 us reset, 3 ms suspend, 1 ms resume.
    localparam int unsigned DEF_RESET_CYCLES   = 1023;
    localparam int unsigned DEF_SUSPEND_CYCLES = 144000;
    localparam int unsigned DEF_RESUME_CYCLES  = 48000;

    // Largest of three thresholds; sizes the shared run counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/usb_line_sync.sv
// D+/D- synchronizer and line decoder. Produces the decoded value about to be
// registered (line_next) and the registered line_state, 3 clk after the pins.
module usb_line_sync
    import usb_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        usb_p_rx,
    input  logic        usb_n_rx,
    output line_state_t line_next,
    output line_state_t line_state
);

    logic p_meta;
    logic p_sync;
    logic n_meta;
    logic n_sync;

    // Two-flop synchronizers for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_meta <= 1'b0;
            p_sync <= 1'b0;
            n_meta <= 1'b0;
            n_sync <= 1'b0;
        end else begin
            p_meta <= usb_p_rx;
            p_sync <= p_meta;
            n_meta <= usb_n_rx;
            n_sync <= n_meta;
        end
    end

    // Decode the synchronized pin pair into a line value.
    always_comb begin
        line_next = LS_SE0;
        case ({p_sync, n_sync})
            2'b10:   line_next = LS_J;
            2'b01:   line_next = LS_K;
            2'b11:   line_next = LS_SE1;
            default: line_next = LS_SE0;
        endcase
    end

    // Register the decoded line.
    always_ff @(posedge clk) begin
        if (reset) line_state <= LS_SE0;
        else       line_state <= line_next;
    end

endmodule

// File: rtl/usb_bus_state_ctrl.sv
// USB full-speed bus-state controller: times runs of identical line samples
// and sequences ACTIVE / BUS_RESET / SUSPEND / RESUME. bus_state is the FSM
// state register itself, so it doubles as the state debug view.
module usb_bus_state_ctrl
    import usb_bus_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int unsigned SUSPEND_CYCLES = DEF_SUSPEND_CYCLES,
    parameter int unsigned RESUME_CYCLES  = DEF_RESUME_CYCLES
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    output logic       bus_reset,
    output logic       reset_start,
    output logic       suspend,
    output logic       resume_pulse,
    output logic [1:0] line_state,
    output logic [1:0] bus_state
);

    localparam int unsigned CNT_W = $clog2(max3(RESET_CYCLES, SUSPEND_CYCLES, RESUME_CYCLES) + 1);
    localparam logic [CNT_W-1:0] RESET_MATCH   = RESET_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] SUSPEND_MATCH = SUSPEND_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] RESUME_MATCH  = RESUME_CYCLES[CNT_W-1:0];

    line_state_t      line_next;
    line_state_t      line_q;
    logic [CNT_W-1:0] run_cnt;
    bus_state_t       state;
    bus_state_t       state_next;
    logic             reset_start_next;
    logic             resume_pulse_next;

    usb_line_sync u_line_sync (
        .clk        (clk),
        .reset      (reset),
        .usb_p_rx   (usb_p_rx),
        .usb_n_rx   (usb_n_rx),
        .line_next  (line_next),
        .line_state (line_q)
    );

    // Run length of the registered line: restarts at 1 on a change and
    // saturates, so each equality match below fires once per run.
    always_ff @(posedge clk) begin
        if (reset)                    run_cnt <= '0;
        else if (line_next != line_q) run_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (run_cnt != '1)       run_cnt <= run_cnt + 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_ACTIVE;
        else       state <= state_next;
    end

    // Next-state and event decode from the registered line and run length.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACTIVE: begin
                if (line_q == LS_SE0 && run_cnt == RESET_MATCH)     state_next = ST_BUS_RESET;
                else if (line_q == LS_J && run_cnt == SUSPEND_MATCH) state_next = ST_SUSPEND;
            end
            ST_BUS_RESET: begin
                if (line_q != LS_SE0) state_next = ST_ACTIVE;
            end
            ST_SUSPEND: begin
                if (line_q == LS_K && run_cnt == RESUME_MATCH)        state_next = ST_RESUME;
                else if (line_q == LS_SE0 && run_cnt == RESET_MATCH) state_next = ST_BUS_RESET;
            end
            ST_RESUME: begin
                if (line_q == LS_J)                                   state_next = ST_ACTIVE;
                else if (line_q == LS_SE0 && run_cnt == RESET_MATCH) state_next = ST_BUS_RESET;
            end
            default: state_next = ST_ACTIVE;
        endcase
        reset_start_next  = (state_next == ST_BUS_RESET) && (state != ST_BUS_RESET);
        resume_pulse_next = (state == ST_SUSPEND) && (state_next == ST_RESUME);
    end

    // Registered outputs, aligned with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_reset    <= 1'b0;
            suspend      <= 1'b0;
            reset_start  <= 1'b0;
            resume_pulse <= 1'b0;
        end else begin
            bus_reset    <= (state_next == ST_BUS_RESET);
            suspend      <= (state_next == ST_SUSPEND);
            reset_start  <= reset_start_next;
            resume_pulse <= resume_pulse_next;
        end
    end

    assign line_state = line_q;
    assign bus_state  = state;

endmodule

// File: tb/tb_usb_bus_state_ctrl.sv
// Testbench for usb_bus_state_ctrl with short thresholds.
module tb_usb_bus_state_ctrl;

    localparam int RST_N   = 8;
    localparam int SUSP_N  = 32;
    localparam int RES_N   = 16;
    localparam int CNT_W   = $clog2(SUSP_N + 1);
    localparam int RUN_MAX = (1 << CNT_W) - 1;
    localparam int W       = 8 + CNT_W;

    // Line codes and bus states as numbered on the outputs.
    localparam int L_SE0 = 0, L_J = 1, L_K = 2, L_SE1 = 3;
    localparam int S_ACT = 0, S_RST = 1, S_SUS = 2, S_RES = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic usb_p_rx = 1'b1;
    logic usb_n_rx = 1'b0;
    logic bus_reset, reset_start, suspend, resume_pulse;
    logic [1:0] line_state, bus_state;

    always #5 clk = ~clk;

    usb_bus_state_ctrl #(
        .RESET_CYCLES   (RST_N),
        .SUSPEND_CYCLES (SUSP_N),
        .RESUME_CYCLES  (RES_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .usb_p_rx     (usb_p_rx),
        .usb_n_rx     (usb_n_rx),
        .bus_reset    (bus_reset),
        .reset_start  (reset_start),
        .suspend      (suspend),
        .resume_pulse (resume_pulse),
        .line_state   (line_state),
        .bus_state    (bus_state)
    );

    // ---------------- reference model + scoreboard ----------------
    // Each clock the model pushes the expected output vector
    // {bus_reset, reset_start, suspend, resume_pulse, line_state, bus_state, run}.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    int pin_hist[$];  // line seen on the pins at the last two sampling edges
    int m_line = 0;
    int m_run  = 0;
    int m_st   = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    always @(posedge clk) begin : ref_model
        int nl, nrun, nst, rs, rp, pin_line;
        rs = 0;
        rp = 0;
        if (usb_p_rx && !usb_n_rx)      pin_line = L_J;
        else if (!usb_p_rx && usb_n_rx) pin_line = L_K;
        else if (usb_p_rx && usb_n_rx)  pin_line = L_SE1;
        else                            pin_line = L_SE0;
        if (reset) begin
            pin_hist = '{L_SE0, L_SE0};
            m_line = L_SE0;
            m_run  = 0;
            m_st   = S_ACT;
        end else begin
            nl = pin_hist.pop_front();
            pin_hist.push_back(pin_line);
            if (nl != m_line)        nrun = 1;
            else if (m_run < RUN_MAX) nrun = m_run + 1;
            else                     nrun = RUN_MAX;
            nst = m_st;
            if (m_st == S_ACT) begin
                if (m_line == L_SE0 && m_run == RST_N)     nst = S_RST;
                else if (m_line == L_J && m_run == SUSP_N) nst = S_SUS;
            end else if (m_st == S_RST) begin
                if (m_line != L_SE0) nst = S_ACT;
            end else if (m_st == S_SUS) begin
                if (m_line == L_K && m_run == RES_N)        nst = S_RES;
                else if (m_line == L_SE0 && m_run == RST_N) nst = S_RST;
            end else begin
                if (m_line == L_J)                          nst = S_ACT;
                else if (m_line == L_SE0 && m_run == RST_N) nst = S_RST;
            end
            rs = (nst == S_RST && m_st != S_RST) ? 1 : 0;
            rp = (m_st == S_SUS && nst == S_RES) ? 1 : 0;
            m_line = nl;
            m_run  = nrun;
            m_st   = nst;
        end
        exp_q.push_back({1'(m_st == S_RST), 1'(rs), 1'(m_st == S_SUS), 1'(rp),
                         2'(m_line), 2'(m_st), CNT_W'(m_run)});
    end

    function automatic logic [W-1:0] obs();
        return {bus_reset, reset_start, suspend, resume_pulse, line_state, bus_state, dut.run_cnt};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_line(input int ls);
        usb_p_rx = (ls == L_J) || (ls == L_SE1);
        usb_n_rx = (ls == L_K) || (ls == L_SE1);
    endtask

    // Advance one clock and fetch the model's expectation for it.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        if (exp_q.size() == 1) exp_v = exp_q.pop_front();
        else                   exp_v = 'x;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        set_line(L_J);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL reset_model cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
        end
        n_cmp++;
        if ({bus_reset, reset_start, suspend, resume_pulse, line_state, bus_state} !== 8'h00
            || dut.run_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got %b/%0d expected all zero",
                     {bus_reset, reset_start, suspend, resume_pulse, line_state, bus_state}, dut.run_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_bus_reset();
        int seg_line[3] = '{L_J, L_SE0, L_J};
        int seg_len[3]  = '{10, 20, 8};
        int pulses = 0;
        int rise = -1;
        for (int s = 0; s < 3; s++) begin
            set_line(seg_line[s]);
            for (int c = 0; c < seg_len[s]; c++) begin
                tick();
                n_cmp++;
                if (obs() !== exp_v) begin
                    n_bad++;
                    $display("FAIL bus_reset_model seg %0d cyc %0d: got %h expected %h", s, c, obs(), exp_v);
                end
                if (s == 1 && reset_start) pulses++;
                if (s == 1 && bus_reset && rise < 0) rise = c + 1;
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL bus_reset_pulses: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (rise != RST_N + 3) begin
            n_bad++;
            $display("FAIL bus_reset_rise: got %0d expected %0d", rise, RST_N + 3);
        end
        n_cmp++;
        if (bus_reset !== 1'b0 || bus_state !== 2'(S_ACT)) begin
            n_bad++;
            $display("FAIL bus_reset_end: got %b/%0d expected 0/%0d", bus_reset, bus_state, S_ACT);
        end
    endtask

    task automatic test_short_se0();
        int seg_line[3] = '{L_J, L_SE0, L_J};
        int seg_len[3]  = '{5, RST_N - 1, 6};
        int events = 0;
        for (int s = 0; s < 3; s++) begin
            set_line(seg_line[s]);
            for (int c = 0; c < seg_len[s]; c++) begin
                tick();
                n_cmp++;
                if (obs() !== exp_v) begin
                    n_bad++;
                    $display("FAIL short_se0_model seg %0d cyc %0d: got %h expected %h", s, c, obs(), exp_v);
                end
                if (reset_start || bus_reset) events++;
                if (s == 2 && c == 2) begin
                    n_cmp++;
                    if (line_state !== 2'(L_J) || dut.run_cnt !== CNT_W'(1)) begin
                        n_bad++;
                        $display("FAIL short_se0_restart: got line %0d run %0d expected line 1 run 1",
                                 line_state, dut.run_cnt);
                    end
                end
            end
        end
        n_cmp++;
        if (events != 0) begin
            n_bad++;
            $display("FAIL short_se0_events: got %0d expected 0", events);
        end
    endtask

    task automatic test_suspend_resume();
        int seg_line[7] = '{L_SE0, L_J, L_K, L_J, L_K, L_SE0, L_J};
        int seg_len[7]  = '{2, 40, 10, 5, 22, 2, 6};
        int sus_rise = -1;
        int pulses = 0;
        int pulse_at = -1;
        int sus_drop = 0;
        for (int s = 0; s < 7; s++) begin
            set_line(seg_line[s]);
            for (int c = 0; c < seg_len[s]; c++) begin
                tick();
                n_cmp++;
                if (obs() !== exp_v) begin
                    n_bad++;
                    $display("FAIL suspend_model seg %0d cyc %0d: got %h expected %h", s, c, obs(), exp_v);
                end
                if (s == 1 && suspend && sus_rise < 0) sus_rise = c + 1;
                if ((s == 2 || s == 3) && !suspend) sus_drop++;
                if (resume_pulse) begin
                    pulses++;
                    if (s == 4) pulse_at = c + 1;
                end
            end
            if (s == 4) begin
                n_cmp++;
                if (bus_state !== 2'(S_RES) || suspend !== 1'b0) begin
                    n_bad++;
                    $display("FAIL resume_state: got %0d/%b expected %0d/0", bus_state, suspend, S_RES);
                end
            end
        end
        n_cmp++;
        if (sus_rise != SUSP_N + 3) begin
            n_bad++;
            $display("FAIL suspend_rise: got %0d expected %0d", sus_rise, SUSP_N + 3);
        end
        n_cmp++;
        if (sus_drop != 0) begin
            n_bad++;
            $display("FAIL suspend_hold_short_k: got %0d low cycles expected 0", sus_drop);
        end
        n_cmp++;
        if (pulses != 1 || pulse_at != RES_N + 3) begin
            n_bad++;
            $display("FAIL resume_pulse: got %0d pulses at %0d expected 1 at %0d", pulses, pulse_at, RES_N + 3);
        end
        n_cmp++;
        if (bus_state !== 2'(S_ACT) || suspend !== 1'b0) begin
            n_bad++;
            $display("FAIL resume_to_active: got %0d/%b expected %0d/0", bus_state, suspend, S_ACT);
        end
    endtask

    task automatic test_suspend_to_reset();
        int seg_line[3] = '{L_J, L_SE0, L_J};
        int seg_len[3]  = '{40, RST_N + 6, 8};
        int pulses = 0;
        int bad_edge = 0;
        int seen_rise = 0;
        logic prev_sus = 1'b0;
        logic prev_rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            set_line(seg_line[s]);
            for (int c = 0; c < seg_len[s]; c++) begin
                tick();
                n_cmp++;
                if (obs() !== exp_v) begin
                    n_bad++;
                    $display("FAIL sus_reset_model seg %0d cyc %0d: got %h expected %h", s, c, obs(), exp_v);
                end
                if (s == 1) begin
                    if (reset_start) pulses++;
                    if (bus_reset && !prev_rst) begin
                        seen_rise++;
                        if (!(prev_sus && !suspend)) bad_edge++;
                    end
                    if (bus_state == 2'(S_ACT) || bus_state == 2'(S_RES)) bad_edge++;
                end
                prev_sus = suspend;
                prev_rst = bus_reset;
            end
        end
        n_cmp++;
        if (seen_rise != 1 || bad_edge != 0 || pulses != 1) begin
            n_bad++;
            $display("FAIL suspend_to_reset: got rises %0d bad %0d pulses %0d expected 1/0/1",
                     seen_rise, bad_edge, pulses);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        set_line(L_J);
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL sat_model pre cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
        end
        set_line(L_SE0);
        for (int c = 0; c < (1 << CNT_W) + 50; c++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL sat_model cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
            if (reset_start) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || bus_reset !== 1'b1 || dut.run_cnt !== CNT_W'(RUN_MAX)) begin
            n_bad++;
            $display("FAIL saturation: got pulses %0d bus_reset %b run %0d expected 1/1/%0d",
                     pulses, bus_reset, dut.run_cnt, RUN_MAX);
        end
    endtask

    task automatic test_reset_midway();
        int pulses = 0;
        set_line(L_SE0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus_state !== 2'(S_ACT) || bus_reset !== 1'b0 || reset_start !== 1'b0 || dut.run_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_midway_abort: got state %0d bus_reset %b start %b run %0d expected 0/0/0/0",
                     bus_state, bus_reset, reset_start, dut.run_cnt);
        end
        for (int c = 0; c < RST_N + 8; c++) begin
            tick();
            n_cmp++;
            if (obs() !== exp_v) begin
                n_bad++;
                $display("FAIL reset_midway_model cyc %0d: got %h expected %h", c, obs(), exp_v);
            end
            if (reset_start) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || bus_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_midway_reentry: got pulses %0d bus_reset %b expected 1/1", pulses, bus_reset);
        end
    endtask

    task automatic test_random();
        int ls, len, sel;
        for (int s = 0; s < 70; s++) begin
            if ($urandom_range(0, 19) == 0) reset = 1'b1;
            ls  = $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       len = $urandom_range(1, 6);
                1:       len = $urandom_range(RST_N - 1, RST_N + 4);
                2:       len = $urandom_range(RES_N - 2, RES_N + 6);
                default: len = $urandom_range(SUSP_N - 2, SUSP_N + 8);
            endcase
            set_line(ls);
            for (int c = 0; c < len; c++) begin
                tick();
                reset = 1'b0;
                n_cmp++;
                if (obs() !== exp_v) begin
                    n_bad++;
                    $display("FAIL random seg %0d cyc %0d line %0d: got %h expected %h", s, c, ls, obs(), exp_v);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_bus_reset();
        test_short_se0();
        test_suspend_resume();
        test_suspend_to_reset();
        test_saturation();
        test_reset_midway();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
